dm_port_arbiter: RTL
====================

# dm_port_arbiter

Shares the single synchronous-read data RAM port between the instruction-fetch requester (IF, read-only) and the memory-stage requester (MEM, read/write with byte enables). Sits between the IF/MEM stage memory interfaces and the RAM. It serialises accesses, returns load data two cycles after grant, and prevents MEM from starving IF.

## Interface
Parameters:
- STARVE_LIMIT, 4 — MEM-win cycles tolerated while IF is pending before IF is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  IF read request; held with if_addr stable until granted.
- if_addr  in  32  IF word address.
- if_gnt  out  1  IF request accepted this cycle (combinational).
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  32  IF read data.
- mem_req  in  1  MEM request; held with mem_addr/mem_wen/mem_wdata stable until granted.
- mem_addr  in  32  MEM byte address.
- mem_wen  in  4  byte write enables; 4'b0000 means read.
- mem_wdata  in  32  MEM write data, already lane-aligned.
- mem_gnt  out  1  MEM request accepted this cycle (combinational).
- mem_rvalid  out  1  one-cycle pulse; mem_rdata valid (reads only).
- mem_rdata  out  32  MEM read data (raw word, no extension).
- ram_addr  out  32  RAM address.
- ram_wen  out  4  RAM byte write enables.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid one cycle after the address.

## Operation
- FSM states: IDLE, RD_WAIT, RESP. Reset state is IDLE.
- Grant is possible only in IDLE or RESP. At most one grant per cycle.
- Transfer happens when req and gnt are both high in the same cycle.
- Arbitration: MEM wins by default. IF wins instead when starve_cnt == STARVE_LIMIT.
- starve_cnt is 4 bits:
  - Increments when MEM is granted while if_req is high.
  - Clears when IF is granted or if_req is low.
  - Saturates at STARVE_LIMIT.
- On grant:
  - ram_addr is driven by the winner's address.
  - ram_wen is mem_wen when MEM wins, otherwise 0.
  - ram_wdata is mem_wdata.
  - With no grant: ram_wen = 0, ram_addr = 0, ram_wdata = 0.
- Write grant (mem_wen ≠ 0):
  - The write completes in the grant cycle.
  - No rvalid is issued.
  - Next state is IDLE.
  - Back-to-back writes are allowed every cycle.
- Read grant:
  - A 1-bit owner register records IF or MEM.
  - Next state is RD_WAIT.
  - In RD_WAIT: no grant; ram_rdata is captured into rdata_r; next state is RESP.
- RESP:
  - rvalid pulses for the owner.
  - Both if_rdata and mem_rdata are driven from rdata_r.
  - A new grant may be issued in the same cycle.
  - Next state is RD_WAIT if a read was granted, else IDLE.
- rdata outputs hold their last value between pulses.

## Timing
- Reset values: if_gnt = mem_gnt = 0 (FSM in IDLE, but gnt still follows req combinationally once reset is low), if_rvalid = mem_rvalid = 0, if_rdata = mem_rdata = 0, ram_wen = 0, starve_cnt = 0, owner = MEM.
- While reset is high, both gnt outputs are forced to 0 and ram_wen to 0.
- Read latency: grant in cycle N, rvalid in cycle N+2.
- Sustained read throughput: one read per 2 cycles (RESP overlaps the next grant).
- Write latency: 0 cycles; RAM is written at the edge ending the grant cycle.
- Reset asserted in RD_WAIT or RESP: the outstanding read is discarded, no rvalid is issued, and the FSM goes to IDLE.
- Both requesters high in IDLE with starve_cnt < STARVE_LIMIT: MEM granted and starve_cnt increments.
- Read followed by a write to the same address: the write can only be granted in RESP or later, so the read always returns pre-write data.
- A requester that drops req before grant is simply not serviced; no error is raised.

## Test plan
- MEM read, RAM[0x10] = 0xDEADBEEF: mem_req, mem_wen = 0, addr 0x10 in cycle 0 -> mem_gnt in cycle 0; mem_rvalid with 0xDEADBEEF in cycle 2; if_rvalid stays 0.
- MEM write, wen = 4'b0010, wdata = 0x0000AB00 at addr 0x20 -> ram_wen = 0010 in the grant cycle, no rvalid; a following read of 0x20 returns byte 1 = 0xAB.
- Contention with STARVE_LIMIT = 4: both requesters continuously high, MEM issuing writes -> MEM granted 4 consecutive cycles, IF granted on the 5th, then starve_cnt = 0.
- Pipelined reads: IF then MEM reads to 0x0 and 0x4 -> grants in cycles 0 and 2; if_rvalid in cycle 2; mem_rvalid in cycle 4 with correct data.
- Reset pulse in cycle 1 after a read grant in cycle 0 -> no rvalid in cycle 2; all outputs at reset values; the next request is granted normally.
- Read of 0x30 then write of 0x30 requested in the next cycle -> write granted in RESP; the read returns the old value.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Arbitrates the single synchronous-read data RAM port between instruction fetch and the memory stage.
// MEM wins by default; a saturating starvation counter forces IF through after STARVE_LIMIT MEM wins.
module dm_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_wdata,
  output logic        mem_gnt,
  output logic        mem_rvalid,
  output logic [31:0] mem_rdata,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q;
  logic        owner_q;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] rdata_q;
  logic        if_rvalid_q, mem_rvalid_q;
  logic        can_grant, if_forced, read_gnt;

  always_comb begin
    can_grant = !reset && ((state_q == IDLE) || (state_q == RESP));
    if_forced = if_req && (starve_q == LIMIT);
    if_gnt    = can_grant && if_req && (if_forced || !mem_req);
    mem_gnt   = can_grant && mem_req && !if_forced;
    read_gnt  = if_gnt || (mem_gnt && (mem_wen == 4'b0000));

    ram_addr  = '0;
    ram_wen   = '0;
    ram_wdata = '0;
    if (if_gnt) begin
      ram_addr  = if_addr;
      ram_wdata = mem_wdata;
    end else if (mem_gnt) begin
      ram_addr  = mem_addr;
      ram_wen   = mem_wen;
      ram_wdata = mem_wdata;
    end

    // Counts only MEM wins that happen while IF is actually waiting.
    starve_d = starve_q;
    if (if_gnt || !if_req) begin
      starve_d = '0;
    end else if (mem_gnt && (starve_q < LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      starve_q     <= '0;
      rdata_q      <= '0;
      if_rvalid_q  <= 1'b0;
      mem_rvalid_q <= 1'b0;
    end else begin
      starve_q     <= starve_d;
      if_rvalid_q  <= 1'b0;
      mem_rvalid_q <= 1'b0;
      case (state_q)
        RD_WAIT: begin
          rdata_q      <= ram_rdata;
          if_rvalid_q  <= owner_q;
          mem_rvalid_q <= !owner_q;
          state_q      <= RESP;
        end
        IDLE, RESP: begin
          // RESP overlaps the next grant, giving one read every two cycles.
          if (read_gnt) begin
            owner_q <= if_gnt;
            state_q <= RD_WAIT;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_rvalid  = if_rvalid_q;
  assign mem_rvalid = mem_rvalid_q;
  assign if_rdata   = rdata_q;
  assign mem_rdata  = rdata_q;

endmodule
